// File: rtl/sram_march_bist_if.sv
// Shared SRAM bus between the march BIST engine (master) and the macros under
// test (slave). One select/write/address/data-in set fans out to every macro;
// the read data of all macros comes back concatenated on sram_dout.
interface sram_march_bist_if #(
  parameter int NUM_SRAMS  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                              sram_csb;
  logic                              sram_web;
  logic [ADDR_WIDTH-1:0]             sram_addr;
  logic [DATA_WIDTH-1:0]             sram_din;
  logic [NUM_SRAMS*DATA_WIDTH-1:0]   sram_dout;

  modport master (
    output sram_csb, sram_web, sram_addr, sram_din,
    input  sram_dout
  );

  modport slave (
    input  sram_csb, sram_web, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram_march_bist.sv
// sram_march_bist: March test engine for NUM_SRAMS macros in parallel.
// Sequence: W0 (write pattern, up), RW (read pattern / write ~pattern, up),
// R1 (read ~pattern, down), DRAIN (retire outstanding compares), DONE.
// Optional first-failure capture (err_addr/err_phase) is built only when
// SRAM_BIST_ERR_CAPTURE_EN is defined.
module sram_march_bist #(
  parameter int NUM_SRAMS    = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            abort,
  input  logic [DATA_WIDTH-1:0]           pattern,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [NUM_SRAMS-1:0]            fail,
`ifdef SRAM_BIST_ERR_CAPTURE_EN
  output logic [NUM_SRAMS*ADDR_WIDTH-1:0] err_addr,
  output logic [NUM_SRAMS*2-1:0]          err_phase,
`endif
  sram_march_bist_if.master               sram
);

  typedef enum logic [2:0] {IDLE, W0, RW, R1, DRAIN, DONE} state_e;

  state_e                                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]                    cnt_q, cnt_d;
  logic                                     ph_q, ph_d;
  logic [2:0]                               drn_q, drn_d;
  logic [DATA_WIDTH-1:0]                    pat_q, pat_d;
  logic [NUM_SRAMS-1:0]                     fail_q, fail_d;
  logic                                     busy_q, busy_d;
  logic                                     done_q, done_d;
  logic                                     csb_q, csb_d;
  logic                                     web_q, web_d;
  logic [ADDR_WIDTH-1:0]                    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]                    din_q, din_d;
  logic [READ_LATENCY:0]                    rv_q, rv_d;
  logic [READ_LATENCY:0][DATA_WIDTH-1:0]    exp_q, exp_d;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
  logic [READ_LATENCY:0][ADDR_WIDTH-1:0]    ea_q, ea_d;
  logic [READ_LATENCY:0][1:0]               ep_q, ep_d;
  logic [NUM_SRAMS*ADDR_WIDTH-1:0]          err_addr_q, err_addr_d;
  logic [NUM_SRAMS*2-1:0]                   err_phase_q, err_phase_d;
`endif

  logic                  flush, acc, wr, rd, cmp_en;
  logic [DATA_WIDTH-1:0] exp_new, rd_word;

  // Next-state, compare, and registered bus outputs derived from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    drn_d   = drn_q;
    pat_d   = pat_q;
    fail_d  = fail_q;
    flush   = 1'b0;
    rd_word = '0;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
    err_addr_d  = err_addr_q;
    err_phase_d = err_phase_q;
`endif

    // Stage READ_LATENCY lines up with the returned word; an abort edge drops it
    cmp_en = rv_q[READ_LATENCY] && !(abort && busy_q);
    for (int unsigned i = 0; i < NUM_SRAMS; i++) begin
      rd_word = sram.sram_dout[i*DATA_WIDTH +: DATA_WIDTH];
      if (cmp_en && (rd_word != exp_q[READ_LATENCY])) begin
        fail_d[i] = 1'b1;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
        if (!fail_q[i]) begin
          err_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = ea_q[READ_LATENCY];
          err_phase_d[i*2 +: 2]                  = ep_q[READ_LATENCY];
        end
`endif
      end
    end

    if (abort && busy_q) begin
      state_d = IDLE;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && !abort) begin
            state_d = W0;
            cnt_d   = '0;
            ph_d    = 1'b0;
            pat_d   = pattern;
            fail_d  = '0;
            flush   = 1'b1;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
            err_addr_d  = '0;
            err_phase_d = '0;
`endif
          end
        end
        W0: begin
          if (cnt_q == '1) begin
            state_d = RW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
        RW: begin
          ph_d = ~ph_q;
          if (ph_q) begin
            if (cnt_q == '1) state_d = R1;
            else             cnt_d   = cnt_q + ADDR_WIDTH'(1);
          end
        end
        R1: begin
          if (cnt_q == '0) begin
            state_d = DRAIN;
            drn_d   = '0;
          end else begin
            cnt_d = cnt_q - ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Held one edge past the last compare so fail is settled when done rises
          if (drn_q == 3'(READ_LATENCY)) state_d = DONE;
          else                           drn_d   = drn_q + 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Bus registers carry the access belonging to the state being entered
    acc     = (state_d == W0) || (state_d == RW) || (state_d == R1);
    wr      = (state_d == W0) || ((state_d == RW) && ph_d);
    rd      = acc && !wr;
    csb_d   = !acc;
    web_d   = !wr;
    addr_d  = acc ? cnt_d : '0;
    din_d   = !wr ? '0 : ((state_d == W0) ? pat_d : ~pat_d);
    exp_new = (state_d == RW) ? pat_d : ~pat_d;
    busy_d  = acc || (state_d == DRAIN);
    done_d  = (state_d == DONE);

    rv_d  = flush ? '0 : {rv_q[READ_LATENCY-1:0], rd};
    exp_d = {exp_q[READ_LATENCY-1:0], exp_new};
`ifdef SRAM_BIST_ERR_CAPTURE_EN
    ea_d = {ea_q[READ_LATENCY-1:0], cnt_d};
    ep_d = {ep_q[READ_LATENCY-1:0], ((state_d == RW) ? 2'd1 : 2'd2)};
`endif
  end

  // State, counters, compare pipeline and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      drn_q   <= '0;
      pat_q   <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      rv_q    <= '0;
      exp_q   <= '0;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
      ea_q        <= '0;
      ep_q        <= '0;
      err_addr_q  <= '0;
      err_phase_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      drn_q   <= drn_d;
      pat_q   <= pat_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rv_q    <= rv_d;
      exp_q   <= exp_d;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
      ea_q        <= ea_d;
      ep_q        <= ep_d;
      err_addr_q  <= err_addr_d;
      err_phase_q <= err_phase_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q & ~|fail_q;
  assign fail           = fail_q;
  assign sram.sram_csb  = csb_q;
  assign sram.sram_web  = web_q;
  assign sram.sram_addr = addr_q;
  assign sram.sram_din  = din_q;
`ifdef SRAM_BIST_ERR_CAPTURE_EN
  assign err_addr  = err_addr_q;
  assign err_phase = err_phase_q;
`endif

endmodule
